// File: rtl/fetch_hazard_ctrl_if.sv
// ============================================================================
// Module      : fetch_hazard_ctrl_if
// Description : Hazard inputs and front-end control outputs of fetch_hazard_ctrl
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fetch_hazard_ctrl_if;
    logic       is_two_byte;
    logic       id_ex_mem_read;
    logic [1:0] id_ex_rd;
    logic [1:0] if_id_ra;
    logic [1:0] if_id_rb;
    logic       uses_ra;
    logic       uses_rb;
    logic       branch_taken;
    logic       irq;
    logic       pc_write;
    logic [1:0] pc_sel;
    logic       if_id_en;
    logic       flush;
    logic       imm_capture;
    logic       id_ex_bubble;
    logic       irq_ack;
    logic       ip_save;
    logic [2:0] state;

    // master: the sequencer; slave: the pipeline/hazard side it talks to
    modport master (
        input  is_two_byte, id_ex_mem_read, id_ex_rd, if_id_ra, if_id_rb,
               uses_ra, uses_rb, branch_taken, irq,
        output pc_write, pc_sel, if_id_en, flush, imm_capture,
               id_ex_bubble, irq_ack, ip_save, state
    );

    modport slave (
        output is_two_byte, id_ex_mem_read, id_ex_rd, if_id_ra, if_id_rb,
               uses_ra, uses_rb, branch_taken, irq,
        input  pc_write, pc_sel, if_id_en, flush, imm_capture,
               id_ex_bubble, irq_ack, ip_save, state
    );
endinterface

`default_nettype wire

// File: rtl/fetch_hazard_ctrl.sv
// ============================================================================
// Module      : fetch_hazard_ctrl
// Description : Front-end sequencer (two-byte fetch, load-use stall, branch
//               flush, interrupt entry when FETCH_CTRL_IRQ_EN is defined)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_hazard_ctrl #(
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int CNT_W             = 2
) (
    input  wire logic          clk,
    input  wire logic          rst,
    fetch_hazard_ctrl_if.master bus
);

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_IMM       = 3'd1,
        S_STALL     = 3'd2,
        S_IRQ_FLUSH = 3'd3,
        S_IRQ_VEC   = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] C_CNT_LOAD     = CNT_W'(LOAD_STALL_CYCLES - 1);
    localparam state_t           C_AFTER_HAZARD = (LOAD_STALL_CYCLES > 1) ? S_STALL : S_FETCH;

    state_t           r_state, w_next;
    logic [CNT_W-1:0] r_cnt, w_cnt_next;

    logic       w_hazard, w_irq;
    logic       w_pc_write, w_if_id_en, w_flush, w_imm_capture;
    logic       w_id_ex_bubble, w_irq_ack, w_ip_save;
    logic [1:0] w_pc_sel;

    assign w_hazard = bus.id_ex_mem_read &
                      ((bus.uses_ra & (bus.id_ex_rd == bus.if_id_ra)) |
                       (bus.uses_rb & (bus.id_ex_rd == bus.if_id_rb)));

`ifdef FETCH_CTRL_IRQ_EN
    assign w_irq = bus.irq;
`else
    assign w_irq = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_FETCH;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_next         = r_state;
        w_cnt_next     = r_cnt;
        w_pc_write     = 1'b0;
        w_pc_sel       = 2'd0;
        w_if_id_en     = 1'b0;
        w_flush        = 1'b0;
        w_imm_capture  = 1'b0;
        w_id_ex_bubble = 1'b0;
        w_irq_ack      = 1'b0;
        w_ip_save      = 1'b0;

        case (r_state)
            S_FETCH: begin
                if (bus.branch_taken) begin
                    w_flush    = 1'b1;
                    w_pc_sel   = 2'd1;
                    w_pc_write = 1'b1;
                    w_cnt_next = '0;
                end else if (w_hazard) begin
                    w_id_ex_bubble = 1'b1;
                    w_cnt_next     = C_CNT_LOAD;
                    w_next         = C_AFTER_HAZARD;
                end else if (w_irq) begin
                    w_flush   = 1'b1;
                    w_irq_ack = 1'b1;
                    w_next    = S_IRQ_FLUSH;
                end else begin
                    w_pc_write = 1'b1;
                    w_if_id_en = 1'b1;
                    if (bus.is_two_byte) begin
                        w_next = S_IMM;
                    end
                end
            end

            S_IMM: begin
                w_next     = S_FETCH;
                w_pc_write = 1'b1;
                if (bus.branch_taken) begin
                    w_flush  = 1'b1;
                    w_pc_sel = 2'd1;
                end else begin
                    w_imm_capture  = 1'b1;
                    w_id_ex_bubble = 1'b1;
                end
            end

            S_STALL: begin
                // The FETCH cycle that saw the hazard is the first bubble, so
                // leaving on count 1 yields exactly LOAD_STALL_CYCLES bubbles.
                if (bus.branch_taken) begin
                    w_flush    = 1'b1;
                    w_pc_sel   = 2'd1;
                    w_pc_write = 1'b1;
                    w_cnt_next = '0;
                    w_next     = S_FETCH;
                end else if (r_cnt != '0) begin
                    w_id_ex_bubble = 1'b1;
                    w_cnt_next     = r_cnt - 1'b1;
                    if (r_cnt == CNT_W'(1)) begin
                        w_next = S_FETCH;
                    end
                end else begin
                    w_next = S_FETCH;
                end
            end

`ifdef FETCH_CTRL_IRQ_EN
            S_IRQ_FLUSH: begin
                w_flush   = 1'b1;
                w_ip_save = 1'b1;
                w_next    = S_IRQ_VEC;
            end

            S_IRQ_VEC: begin
                w_flush    = 1'b1;
                w_pc_sel   = 2'd2;
                w_pc_write = 1'b1;
                w_next     = S_FETCH;
            end
`endif

            default: begin
                w_next     = S_FETCH;
                w_cnt_next = '0;
            end
        endcase
    end

    // Outputs are forced low for the whole time reset is held
    assign bus.pc_write     = rst & w_pc_write;
    assign bus.pc_sel       = rst ? w_pc_sel : 2'd0;
    assign bus.if_id_en     = rst & w_if_id_en;
    assign bus.flush        = rst & w_flush;
    assign bus.imm_capture  = rst & w_imm_capture;
    assign bus.id_ex_bubble = rst & w_id_ex_bubble;
    assign bus.irq_ack      = rst & w_irq_ack;
    assign bus.ip_save      = rst & w_ip_save;
    assign bus.state        = rst ? r_state : 3'd0;

endmodule

`default_nettype wire

// File: tb/tb_fetch_hazard_ctrl.sv
// ============================================================================
// Module      : tb_fetch_hazard_ctrl
// Description : Scoreboard bench for fetch_hazard_ctrl with LOAD_STALL_CYCLES=2
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_hazard_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;

    fetch_hazard_ctrl_if bus ();

    fetch_hazard_ctrl #(
        .LOAD_STALL_CYCLES (2),
        .CNT_W             (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          step_no = 0;
    logic [11:0] q_exp[$];

    // {state, pc_write, pc_sel, if_id_en, flush, imm_capture, id_ex_bubble, irq_ack, ip_save}
    function automatic logic [11:0] ev(input logic [2:0] st, input logic pcw, input logic [1:0] sel,
                                       input logic en, input logic fl, input logic imm,
                                       input logic bub, input logic ack, input logic ips);
        return {st, pcw, sel, en, fl, imm, bub, ack, ips};
    endfunction

    function automatic logic [11:0] run_exp();
        return ev(3'd0, 1'b1, 2'd1 & 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endfunction

    function automatic logic [11:0] br_exp(input logic [2:0] st);
        return ev(st, 1'b1, 2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    endfunction

    task automatic set_in(input logic two, input logic mr, input logic [1:0] rd,
                          input logic [1:0] ra, input logic [1:0] rb, input logic ua,
                          input logic ub, input logic br, input logic irq);
        bus.is_two_byte    = two;
        bus.id_ex_mem_read = mr;
        bus.id_ex_rd       = rd;
        bus.if_id_ra       = ra;
        bus.if_id_rb       = rb;
        bus.uses_ra        = ua;
        bus.uses_rb        = ub;
        bus.branch_taken   = br;
        bus.irq            = irq;
    endtask

    task automatic idle();
        set_in(1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic step(input logic [11:0] e);
        q_exp.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Monitor: outputs are Mealy and present every cycle, so compare mid-cycle
    always @(negedge clk) begin
        logic [11:0] act, e;
        if (q_exp.size() > 0) begin
            e   = q_exp.pop_front();
            act = {bus.state, bus.pc_write, bus.pc_sel, bus.if_id_en, bus.flush,
                   bus.imm_capture, bus.id_ex_bubble, bus.irq_ack, bus.ip_save};
            checks++;
            step_no++;
            if (act !== e) begin
                errors++;
                $display("FAIL outputs step %0d: got %b, expected %b", step_no, act, e);
            end
        end
    end

    initial begin
        idle();
        @(posedge clk);
        #1;

        // Held in reset: everything low
        step(12'd0);
        step(12'd0);

        // Idle running after release
        rst = 1'b1;
        repeat (3) step(run_exp());

        // Two-byte fetch
        set_in(1'b1, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(run_exp());
        idle();
        step(ev(3'd1, 1'b1, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
        step(run_exp());

        // Load-use on ra: two cycles without pc_write
        set_in(1'b0, 1'b1, 2'd2, 2'd2, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(ev(3'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
        step(ev(3'd2, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
        idle();
        step(run_exp());

        // Load-use on rb
        set_in(1'b0, 1'b1, 2'd3, 2'd0, 2'd3, 1'b0, 1'b1, 1'b0, 1'b0);
        step(ev(3'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
        idle();
        step(ev(3'd2, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
        step(run_exp());

        // Near-miss hazards: register mismatch, not a load, source unused
        set_in(1'b0, 1'b1, 2'd1, 2'd2, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(run_exp());
        set_in(1'b0, 1'b0, 2'd2, 2'd2, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(run_exp());
        set_in(1'b0, 1'b1, 2'd2, 2'd2, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        step(run_exp());

        // Branch in IMM
        set_in(1'b1, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(run_exp());
        set_in(1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(br_exp(3'd1));
        idle();
        step(run_exp());

        // Branch beats a simultaneous hazard in FETCH
        set_in(1'b1, 1'b1, 2'd1, 2'd1, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0);
        step(br_exp(3'd0));
        idle();
        step(run_exp());

        // Branch overrides an in-progress stall
        set_in(1'b0, 1'b1, 2'd1, 2'd1, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(ev(3'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
        set_in(1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(br_exp(3'd2));
        idle();
        step(run_exp());

        // Interrupt entry
        set_in(1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1);
`ifdef FETCH_CTRL_IRQ_EN
        step(ev(3'd0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0));
        step(ev(3'd3, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1));
        step(ev(3'd4, 1'b1, 2'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
`else
        repeat (3) step(run_exp());
`endif
        idle();
        step(run_exp());

        // Reset during a stall
        set_in(1'b0, 1'b1, 2'd2, 2'd2, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(ev(3'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
        rst = 1'b0;
        #1;
        checks++;
        if (dut.r_cnt !== 2'd0) begin
            errors++;
            $display("FAIL stall_counter_reset: got %0d, expected 0", dut.r_cnt);
        end
        step(12'd0);
        idle();
        rst = 1'b1;
        step(run_exp());
        step(run_exp());

        // Reset during IMM: no immediate capture afterwards
        set_in(1'b1, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(run_exp());
        idle();
        rst = 1'b0;
        step(12'd0);
        rst = 1'b1;
        step(run_exp());

        begin
            int n = 0;
            while (q_exp.size() > 0 && n < 10) begin
                @(posedge clk);
                n++;
            end
        end
        if (q_exp.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", q_exp.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fetch_hazard_ctrl.md
# fetch_hazard_ctrl

Front-end sequencer for the 8-bit pipeline. It drives the IF/ID pipeline register's enable and flush inputs, the PC write enable and the PC source select. It handles four cases: two-byte instruction fetch (opcode followed by an immediate byte), load-use stalls, taken-branch flushes and, optionally, interrupt entry. It sits between the fetch/PC logic, the IF/ID register and the hazard-detection inputs from ID/EX.

## Interface
Parameters:
- LOAD_STALL_CYCLES, 1, bubble cycles inserted per load-use hazard; legal range 1..3.
- CNT_W, 2, width of the stall counter; must hold LOAD_STALL_CYCLES.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- is_two_byte  in  1  predecoded from the byte currently being fetched; 1 means an immediate byte follows.
- id_ex_mem_read  in  1  instruction in EX is a load.
- id_ex_rd  in  2  destination register of the instruction in EX.
- if_id_ra, if_id_rb  in  2 each  source registers of the instruction in ID.
- uses_ra, uses_rb  in  1 each  ID instruction reads ra / rb.
- branch_taken  in  1  branch resolved taken this cycle.
- irq  in  1  level interrupt request; only with FETCH_CTRL_IRQ_EN.
- pc_write  out  1  PC register update enable.
- pc_sel  out  2  PC source: 0 = PC+1, 1 = branch target, 2 = interrupt vector.
- if_id_en  out  1  IF/ID opcode/PC/IP load enable.
- flush  out  1  IF/ID synchronous clear.
- imm_capture  out  1  IF/ID immediate-byte load strobe.
- id_ex_bubble  out  1  force a NOP into ID/EX.
- irq_ack  out  1  one-cycle interrupt acknowledge.
- ip_save  out  1  latch the return PC into the IP field.
- state  out  3  current state, for debug.

## Operation
- Encoded FSM states: FETCH=0, IMM=1, STALL=2, IRQ_FLUSH=3, IRQ_VEC=4. Outputs are Mealy, decoded from state and inputs.
- Hazard definition: hazard = id_ex_mem_read & ((uses_ra & id_ex_rd==if_id_ra) | (uses_rb & id_ex_rd==if_id_rb)).
- **FETCH.** Evaluated in strict priority order:
  - branch_taken: flush=1, pc_sel=1, pc_write=1; stay in FETCH. Any pending IMM or stall is abandoned.
  - hazard: pc_write=0, if_id_en=0, id_ex_bubble=1. Load counter with LOAD_STALL_CYCLES-1; go to STALL, or stay in FETCH if LOAD_STALL_CYCLES=1.
  - irq (macro enabled): flush=1, pc_write=0, irq_ack=1; go to IRQ_FLUSH.
  - is_two_byte: pc_write=1, if_id_en=1; go to IMM.
  - otherwise: pc_write=1, if_id_en=1, pc_sel=0.
- **IMM.**
  - Normal: imm_capture=1, if_id_en=0, pc_write=1, id_ex_bubble=1 (opcode not yet complete); go to FETCH.
  - branch_taken in IMM: FETCH branch behaviour applies, imm_capture=0.
- **STALL.**
  - While counter is not 0: pc_write=0, if_id_en=0, id_ex_bubble=1; decrement.
  - At 0: go to FETCH.
  - branch_taken overrides the stall and goes to FETCH with a flush.
- **IRQ_FLUSH.** flush=1, ip_save=1; go to IRQ_VEC.
- **IRQ_VEC.** pc_sel=2, pc_write=1, flush=1; go to FETCH. irq is ignored during IRQ_FLUSH and IRQ_VEC.
- **Reset.** rst low forces state=FETCH and counter=0. All outputs are 0 while rst is low, including pc_sel=0 and state=0.
- **Reset mid-sequence** (IMM, STALL, IRQ_*) aborts it; no ack or capture is produced afterwards.

## Timing
- Unstalled one-byte instruction: if_id_en high in the same cycle it is fetched; throughput 1 instruction/cycle.
- Two-byte instruction: 2 cycles (FETCH, then IMM). The immediate is valid at IF/ID output one cycle after the opcode.
- Load-use hazard: exactly LOAD_STALL_CYCLES cycles with pc_write=0.
- Branch: flush asserted in the same cycle as branch_taken; one squashed slot.
- Interrupt: 3 cycles from irq sampled to the first vector fetch (FETCH, IRQ_FLUSH, IRQ_VEC).
  - irq_ack is high for exactly 1 cycle.
  - ip_save is high 1 cycle after irq_ack.
- Counter never wraps: it decrements only when nonzero.

## Configuration
- Macro: FETCH_CTRL_IRQ_EN.
- Defined: the irq input, states IRQ_FLUSH/IRQ_VEC, and the irq_ack/ip_save logic are present.
- Undefined:
  - The irq port still exists but is ignored.
  - irq_ack, ip_save and pc_sel=2 are tied to 0.
  - States 3 and 4 are unreachable; if entered, the FSM returns to FETCH on the next clock.

## Test plan
- **Reset:** release rst with is_two_byte=0 and no hazards → state=0; pc_write=1, if_id_en=1 on every cycle.
- **Two-byte fetch:** is_two_byte=1 in cycle N → cycle N: if_id_en=1; cycle N+1: imm_capture=1, if_id_en=0, id_ex_bubble=1; cycle N+2: back in FETCH.
- **Load-use:** id_ex_mem_read=1, id_ex_rd=2, if_id_ra=2, uses_ra=1, LOAD_STALL_CYCLES=2 → pc_write=0 for exactly 2 cycles, id_ex_bubble=1 for both.
- **Branch in IMM:** branch_taken=1 while state=1 → flush=1, pc_sel=1, imm_capture=0; next state=0.
- **Interrupt (macro on):** irq=1 in idle FETCH → irq_ack pulses 1 cycle, then ip_save=1, then pc_sel=2 with pc_write=1; flush=1 throughout the 3 cycles. With the macro off, the same stimulus produces no change in the output sequence.
- **Reset mid-stall:** rst low while state=2 → all outputs 0 immediately; after release, state=0 and counter=0.
